// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory.
// Contents:
//   state_e    - controller states (CLEAR wipes memory, RUN serves fetches,
//                LOAD accepts a byte-serial program image)
//   HALT_BYTE  - value written to every byte while clearing
//   imem_clog2 - ceiling log2, used to derive the byte address width
package imem_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  localparam logic [7:0] HALT_BYTE = 8'h00;

  function automatic int imem_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/instruction_memory_loader_if.sv
// Bus bundle between the instruction memory and its two clients.
// Fetch side : fetch_req/fetch_addr in, fetch_ready/fetch_valid/fetch_data/
//              fetch_misaligned out.
// Load side  : load_start/load_valid/load_byte/load_last in,
//              load_ready/load_done out.
// Status     : busy out (memory not in RUN).
// The memory uses the slave modport; the loader/fetch agent uses master.
interface instruction_memory_loader_if #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_BYTES = 2
);
  logic                     fetch_req;
  logic [ADDR_W-1:0]        fetch_addr;
  logic                     fetch_ready;
  logic                     fetch_valid;
  logic [8*INSTR_BYTES-1:0] fetch_data;
  logic                     fetch_misaligned;
  logic                     load_start;
  logic                     load_valid;
  logic [7:0]               load_byte;
  logic                     load_last;
  logic                     load_ready;
  logic                     load_done;
  logic                     busy;

  modport slave (
    input  fetch_req, fetch_addr, load_start, load_valid, load_byte, load_last,
    output fetch_ready, fetch_valid, fetch_data, fetch_misaligned,
           load_ready, load_done, busy
  );

  modport master (
    output fetch_req, fetch_addr, load_start, load_valid, load_byte, load_last,
    input  fetch_ready, fetch_valid, fetch_data, fetch_misaligned,
           load_ready, load_done, busy
  );
endinterface

// File: rtl/imem_byte_array.sv
// DEPTH x 8 byte storage with one synchronous write port and INSTR_BYTES
// registered read lanes. Lane i returns mem[(raddr_i + i) mod DEPTH]; the
// ADDR_W-bit addition wraps naturally because DEPTH = 2**ADDR_W.
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears read register)
//   we_i      - write enable; waddr_i / wdata_i give address and byte
//   re_i      - read enable; raddr_i is the byte address of lane 0
//   rdata_o   - little-endian assembled word, holds when re_i is low
module imem_byte_array #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int INSTR_BYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [7:0]               wdata_i,
  input  logic                     re_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output logic [8*INSTR_BYTES-1:0] rdata_o
);

  logic [7:0]               mem_q [DEPTH];
  logic [8*INSTR_BYTES-1:0] rdata_q;

  // Storage contents are not reset; the controller's CLEAR pass wipes them.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      for (int i = 0; i < INSTR_BYTES; i++) begin
        rdata_q[8*i +: 8] <= mem_q[raddr_i + ADDR_W'(i)];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_memory_loader.sv
// Loadable byte-addressed instruction memory sitting between the boot/debug
// loader and the CPU fetch stage. After reset every byte is wiped to HALT,
// one byte per cycle; then fetches are served with one-cycle latency while a
// byte-serial program load may be started at any time.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous active-high reset
//   bus    - instruction_memory_loader_if slave (fetch, load and busy)
module instruction_memory_loader
  import imem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = imem_clog2(DEPTH),
  parameter int INSTR_BYTES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  instruction_memory_loader_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              misaligned_q, misaligned_d;
  logic              load_done_q, load_done_d;

  logic              fetch_ready;
  logic              load_ready;
  logic              fetch_accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [7:0]        mem_wdata;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return (int'(addr) % INSTR_BYTES) != 0;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CLEAR;
      ptr_q         <= '0;
      fetch_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      load_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      fetch_valid_q <= fetch_valid_d;
      misaligned_q  <= misaligned_d;
      load_done_q   <= load_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        if (ptr_q == LAST_PTR) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
        end
      end
      ST_LOAD: begin
        // A restart request wins over a data beat in the same cycle; the
        // beat is dropped and the image is expected again from byte 0.
        if (bus.load_start) begin
          ptr_d = '0;
        end else if (bus.load_valid) begin
          ptr_d = ptr_q + ADDR_W'(1);
          if (bus.load_last) state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // Output / datapath control logic
  always_comb begin
    // Reset is folded into the combinational handshakes so nothing is
    // offered or written while reset is asserted, whatever the state.
    fetch_ready   = !reset && (state_q == ST_RUN) && !bus.load_start;
    load_ready    = !reset && (state_q == ST_LOAD);
    fetch_accept  = fetch_ready && bus.fetch_req;
    mem_we        = 1'b0;
    mem_waddr     = ptr_q;
    mem_wdata     = HALT_BYTE;
    if (!reset) begin
      case (state_q)
        ST_CLEAR: mem_we = 1'b1;
        ST_LOAD: begin
          mem_we    = bus.load_valid && !bus.load_start;
          mem_wdata = bus.load_byte;
        end
        default: mem_we = 1'b0;
      endcase
    end
    fetch_valid_d = fetch_accept;
    misaligned_d  = fetch_accept && is_misaligned(bus.fetch_addr);
    load_done_d   = load_ready && bus.load_valid && bus.load_last && !bus.load_start;
  end

  imem_byte_array #(
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_array (
    .clk     (clk),
    .rst     (reset),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (fetch_accept),
    .raddr_i (bus.fetch_addr),
    .rdata_o (bus.fetch_data)
  );

  assign bus.fetch_ready      = fetch_ready;
  assign bus.fetch_valid      = fetch_valid_q;
  assign bus.fetch_misaligned = misaligned_q;
  assign bus.load_ready       = load_ready;
  assign bus.load_done        = load_done_q;
  assign bus.busy             = reset || (state_q != ST_RUN);

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Bench for instruction_memory_loader: directed stimulus, a behavioural
// model (byte array + clear countdown + loading flag) checked against the
// DUT every cycle, and literal expectations at the key points.
module tb_instruction_memory_loader;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int IB     = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instruction_memory_loader_if #(.ADDR_W(ADDR_W), .INSTR_BYTES(IB)) bus ();

  instruction_memory_loader #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_BYTES(IB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_mem [DEPTH];
  int          clear_left = 0;
  bit          loading = 1'b0;
  int          lptr = 0;
  bit          m_init = 1'b0;
  logic        m_valid = 1'b0, m_mis = 1'b0, m_done = 1'b0;
  logic [15:0] m_data = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_init = 1'b1; clear_left = DEPTH; loading = 1'b0; lptr = 0;
      m_valid = 1'b0; m_mis = 1'b0; m_done = 1'b0; m_data = '0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
    end else if (clear_left > 0) begin
      clear_left--;
      m_valid = 1'b0; m_mis = 1'b0; m_done = 1'b0;
    end else if (loading) begin
      m_valid = 1'b0; m_mis = 1'b0; m_done = 1'b0;
      if (bus.load_start) lptr = 0;
      else if (bus.load_valid) begin
        m_mem[lptr] = bus.load_byte;
        lptr = (lptr + 1) % DEPTH;
        if (bus.load_last) begin loading = 1'b0; m_done = 1'b1; end
      end
    end else begin
      m_done = 1'b0;
      if (bus.load_start) begin
        loading = 1'b1; lptr = 0; m_valid = 1'b0; m_mis = 1'b0;
      end else if (bus.fetch_req) begin
        int a;
        a = int'(bus.fetch_addr);
        m_valid = 1'b1;
        m_data = '0;
        for (int i = 0; i < IB; i++) m_data = m_data | (16'(m_mem[(a + i) % DEPTH]) << (8 * i));
        m_mis = (a % IB) != 0;
      end else begin
        m_valid = 1'b0; m_mis = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      bit run;
      run = (clear_left == 0) && !loading;
      check("fetch_valid",      32'(bus.fetch_valid),      32'(m_valid));
      check("fetch_misaligned", 32'(bus.fetch_misaligned), 32'(m_mis));
      check("fetch_data",       32'(bus.fetch_data),       32'(m_data));
      check("load_done",        32'(bus.load_done),        32'(m_done));
      check("fetch_ready",      32'(bus.fetch_ready),      32'(!reset && run && !bus.load_start));
      check("load_ready",       32'(bus.load_ready),       32'(!reset && loading));
      check("busy",             32'(bus.busy),             32'(reset || !run));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_ready(input string name, input int expect_n);
    int n;
    n = 0;
    while (!bus.fetch_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(n), 32'(expect_n));
  endtask

  task automatic do_fetch(input logic [7:0] a, input logic [15:0] ed, input logic emis, input string name);
    bus.fetch_req = 1'b1; bus.fetch_addr = a;
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    check({name, "_valid"}, 32'(bus.fetch_valid), 32'h1);
    check({name, "_data"},  32'(bus.fetch_data),  32'(ed));
    check({name, "_mis"},   32'(bus.fetch_misaligned), 32'(emis));
    check({name, "_model"}, 32'(m_data), 32'(ed));
  endtask

  task automatic do_load(input logic [7:0] bytes [$], input string name);
    bus.load_start = 1'b1;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    for (int i = 0; i < bytes.size(); i++) begin
      bus.load_valid = 1'b1; bus.load_byte = bytes[i];
      bus.load_last = (i == bytes.size() - 1);
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    check({name, "_done_pulse"}, 32'(bus.load_done), 32'h1);
    @(posedge clk); #1;
    check({name, "_done_clear"}, 32'(bus.load_done), 32'h0);
  endtask

  initial begin
    logic [7:0] q [$];
    bus.fetch_req = 1'b0; bus.fetch_addr = '0;
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_byte = '0; bus.load_last = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",        32'(bus.busy),        32'h1);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'h0);
    check("rst_fetch_valid", 32'(bus.fetch_valid), 32'h0);
    check("rst_fetch_data",  32'(bus.fetch_data),  32'h0);
    check("rst_load_ready",  32'(bus.load_ready),  32'h0);
    check("rst_load_done",   32'(bus.load_done),   32'h0);
    reset = 1'b0;
    wait_ready("clear_cycles", 256);

    do_fetch(8'h10, 16'h0000, 1'b0, "f10_cleared");

    q = '{8'h21, 8'hFE, 8'h22, 8'hFB};
    do_load(q, "load4");
    do_fetch(8'h00, 16'hFE21, 1'b0, "f00");
    do_fetch(8'h02, 16'hFB22, 1'b0, "f02");
    do_fetch(8'h01, 16'h22FE, 1'b1, "f01_mis");
    do_fetch(8'h04, 16'h0000, 1'b0, "f04_untouched");

    q = {};
    for (int i = 0; i < DEPTH; i++) q.push_back(8'(i));
    do_load(q, "load256");
    do_fetch(8'hFF, 16'h00FF, 1'b1, "fFF_wrap");
    do_fetch(8'h7E, 16'h7F7E, 1'b0, "f7E");

    // back-to-back fetches, one per cycle
    bus.fetch_req = 1'b1; bus.fetch_addr = 8'h10;
    @(posedge clk); #1;
    bus.fetch_addr = 8'h11;
    check("b2b0_data", 32'(bus.fetch_data), 32'h1110);
    @(posedge clk); #1;
    bus.fetch_req = 1'b0;
    check("b2b1_valid", 32'(bus.fetch_valid), 32'h1);
    check("b2b1_data",  32'(bus.fetch_data),  32'h1211);
    check("b2b1_mis",   32'(bus.fetch_misaligned), 32'h1);
    @(posedge clk); #1;
    check("idle_valid", 32'(bus.fetch_valid), 32'h0);
    check("idle_hold",  32'(bus.fetch_data),  32'h1211);

    // load_start and fetch_req collide in RUN
    bus.load_start = 1'b1; bus.fetch_req = 1'b1; bus.fetch_addr = 8'h04;
    #1;
    check("coll_ready", 32'(bus.fetch_ready), 32'h0);
    @(posedge clk); #1;
    bus.load_start = 1'b0; bus.fetch_req = 1'b0;
    check("coll_valid", 32'(bus.fetch_valid), 32'h0);
    check("coll_busy",  32'(bus.busy),        32'h1);
    check("coll_lready", 32'(bus.load_ready), 32'h1);

    // 3 of 5 bytes, then reset
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1; bus.load_byte = 8'hA0 + 8'(i); bus.load_last = 1'b0;
      @(posedge clk); #1;
    end
    bus.load_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_no_done", 32'(bus.load_done), 32'h0);
    wait_ready("reclear_cycles", 256);
    do_fetch(8'h00, 16'h0000, 1'b0, "f00_recleared");
    do_fetch(8'h02, 16'h0000, 1'b0, "f02_recleared");

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
